// File: rtl/vga_sync_generator.sv
// Decodes free-running H/V pixel counts into VGA sync, active-video, pixel
// coordinates and line/frame markers, all delayed by LATENCY register stages.
module vga_sync_generator #(
  parameter int   H_VISIBLE   = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_VISIBLE   = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter int   LATENCY     = 2,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic        clk_25MHz,
  input  logic        reset,
  input  logic [15:0] H_Count,
  input  logic [15:0] V_Count,
  output logic        Hsync,
  output logic        Vsync,
  output logic        video_on,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        line_start,
  output logic        frame_start,
  output logic [7:0]  frame_count,
  output logic        count_error
);

  localparam logic [15:0] H_VIS_LIM    = 16'(H_VISIBLE);
  localparam logic [15:0] H_SYNC_START = 16'(H_VISIBLE + H_FP);
  localparam logic [15:0] H_SYNC_END   = 16'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [15:0] H_MAX        = 16'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [15:0] V_VIS_LIM    = 16'(V_VISIBLE);
  localparam logic [15:0] V_SYNC_START = 16'(V_VISIBLE + V_FP);
  localparam logic [15:0] V_SYNC_END   = 16'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic [15:0] V_MAX        = 16'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] x;
    logic [9:0] y;
    logic       line_start;
    logic       frame_start;
  } bundle_t;

  localparam bundle_t IDLE = '{
    hsync:       ~SYNC_ACTIVE,
    vsync:       ~SYNC_ACTIVE,
    video_on:    1'b0,
    x:           10'd0,
    y:           10'd0,
    line_start:  1'b0,
    frame_start: 1'b0
  };

  logic    h_vis;
  logic    v_vis;
  logic    h_sync_on;
  logic    v_sync_on;
  bundle_t decode;

  bundle_t    stage_d [LATENCY];
  bundle_t    stage_q [LATENCY];
  logic [7:0] frame_count_d;
  logic [7:0] frame_count_q;
  logic       count_error_d;
  logic       count_error_q;

  // Out-of-range counts fail every window test, so they decode as blanking.
  always_comb begin
    h_vis     = H_Count < H_VIS_LIM;
    v_vis     = V_Count < V_VIS_LIM;
    h_sync_on = (H_Count >= H_SYNC_START) && (H_Count <= H_SYNC_END);
    v_sync_on = (V_Count >= V_SYNC_START) && (V_Count <= V_SYNC_END);

    decode             = IDLE;
    decode.hsync       = h_sync_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    decode.vsync       = v_sync_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    decode.video_on    = h_vis && v_vis;
    decode.x           = (h_vis && v_vis) ? H_Count[9:0] : 10'd0;
    decode.y           = (h_vis && v_vis) ? V_Count[9:0] : 10'd0;
    decode.line_start  = (H_Count == 16'd0);
    decode.frame_start = (H_Count == 16'd0) && (V_Count == 16'd0);
  end

  always_comb begin
    stage_d[0] = decode;
    for (int i = 1; i < LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Counting the bundle entering the last stage keeps frame_count aligned
  // with the frame_start pulse seen at the outputs.
  always_comb begin
    frame_count_d = frame_count_q;
    if (stage_d[LATENCY-1].frame_start) begin
      frame_count_d = frame_count_q + 8'd1;
    end
    count_error_d = count_error_q || (H_Count > H_MAX) || (V_Count > V_MAX);
  end

  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= IDLE;
      end
      frame_count_q <= 8'd0;
      count_error_q <= 1'b0;
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= stage_d[i];
      end
      frame_count_q <= frame_count_d;
      count_error_q <= count_error_d;
    end
  end

  assign Hsync       = stage_q[LATENCY-1].hsync;
  assign Vsync       = stage_q[LATENCY-1].vsync;
  assign video_on    = stage_q[LATENCY-1].video_on;
  assign pixel_x     = stage_q[LATENCY-1].x;
  assign pixel_y     = stage_q[LATENCY-1].y;
  assign line_start  = stage_q[LATENCY-1].line_start;
  assign frame_start = stage_q[LATENCY-1].frame_start;
  assign frame_count = frame_count_q;
  assign count_error = count_error_q;

endmodule

// File: tb/tb_vga_sync_generator.sv
// Directed bench for vga_sync_generator: steps H/V by hand, compares every
// output against a delayed reference decode plus hand-computed checkpoints.
module tb_vga_sync_generator;

  localparam int LATENCY = 2;
  localparam logic [24:0] IDLE_EXP = {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0};

  logic        clk_25MHz = 1'b0;
  logic        reset     = 1'b1;
  logic [15:0] h_count   = 16'd300;
  logic [15:0] v_count   = 16'd200;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        line_start;
  logic        frame_start;
  logic [7:0]  frame_count;
  logic        count_error;

  int          check_count = 0;
  int          pass_count  = 0;
  logic [24:0] exp_queue[$];
  logic [7:0]  fc_exp  = 8'd0;
  logic        err_exp = 1'b0;
  int          prev_h  = 0;
  int          prev_v  = 0;
  int          hs_cnt, vs_cnt, vid_cnt, ls_cnt;

  vga_sync_generator #(.LATENCY(LATENCY)) dut (
    .clk_25MHz  (clk_25MHz),
    .reset      (reset),
    .H_Count    (h_count),
    .V_Count    (v_count),
    .Hsync      (hsync),
    .Vsync      (vsync),
    .video_on   (video_on),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .line_start (line_start),
    .frame_start(frame_start),
    .frame_count(frame_count),
    .count_error(count_error)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  // Reference decode of 640x480@60, active-low sync.
  function automatic logic [24:0] exp_bundle(input int h, input int v);
    logic       vis;
    logic       hs;
    logic       vs;
    logic [9:0] x;
    logic [9:0] y;
    vis = (h < 640) && (v < 480);
    hs  = !((h >= 656) && (h <= 751));
    vs  = !((v >= 490) && (v <= 491));
    x   = vis ? 10'(h) : 10'd0;
    y   = vis ? 10'(v) : 10'd0;
    return {hs, vs, vis, x, y, (h == 0), (h == 0) && (v == 0)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h, wanted %0h at %0t", tag, actual, expected, $time);
  endtask

  // Observes the outputs due this cycle, then presents the next count pair.
  task automatic applyStimulus(input int h, input int v);
    logic [24:0] exp_b;
    @(negedge clk_25MHz);
    if (exp_queue.size() == LATENCY) exp_b = exp_queue.pop_front();
    else exp_b = IDLE_EXP;
    if (exp_b[0]) fc_exp = fc_exp + 8'd1;
    if (prev_h > 799 || prev_v > 524) err_exp = 1'b1;
    checkOutput("bundle", 32'({hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start}), 32'(exp_b));
    checkOutput("frame_count", 32'(frame_count), 32'(fc_exp));
    checkOutput("count_error", 32'(count_error), 32'(err_exp));
    if (!hsync) hs_cnt++;
    if (!vsync) vs_cnt++;
    if (video_on) vid_cnt++;
    if (line_start) ls_cnt++;
    reset   = 1'b0;
    h_count = 16'(h);
    v_count = 16'(v);
    exp_queue.push_back(exp_bundle(h, v));
    prev_h = h;
    prev_v = v;
  endtask

  task automatic doReset(input int h, input int v);
    @(negedge clk_25MHz);
    reset   = 1'b1;
    h_count = 16'(h);
    v_count = 16'(v);
    #1;
    checkOutput("rst_bundle", 32'({hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start}), 32'(IDLE_EXP));
    checkOutput("rst_fc", 32'(frame_count), 32'd0);
    checkOutput("rst_err", 32'(count_error), 32'd0);
    @(negedge clk_25MHz);
    checkOutput("rst_hold", 32'({hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start}), 32'(IDLE_EXP));
    exp_queue.delete();
    fc_exp  = 8'd0;
    err_exp = 1'b0;
    prev_h  = 0;
    prev_v  = 0;
  endtask

  task automatic flush(input int v);
    repeat (LATENCY + 2) applyStimulus(760, v);
  endtask

  task automatic clearCounts();
    hs_cnt = 0; vs_cnt = 0; vid_cnt = 0; ls_cnt = 0;
  endtask

  initial begin
    clearCounts();
    doReset(300, 200);

    // Release at (0,0): markers arrive two cycles later with frame_count=1.
    applyStimulus(0, 0);
    applyStimulus(1, 0);
    applyStimulus(2, 0);
    checkOutput("rel_frame_start", 32'(frame_start), 32'd1);
    checkOutput("rel_line_start", 32'(line_start), 32'd1);
    checkOutput("rel_frame_count", 32'(frame_count), 32'd1);

    flush(100);
    clearCounts();
    for (int h = 0; h < 800; h++) begin
      applyStimulus(h, 100);
      if (h == 641) checkOutput("pixel_x_639", 32'(pixel_x), 32'd639);
      if (h == 642) checkOutput("pixel_x_blank", 32'(pixel_x), 32'd0);
    end
    flush(100);
    checkOutput("hsync_width", 32'(hs_cnt), 32'd96);
    checkOutput("video_width", 32'(vid_cnt), 32'd640);
    checkOutput("line_starts", 32'(ls_cnt), 32'd1);

    clearCounts();
    for (int v = 0; v < 525; v++) begin
      applyStimulus(100, v);
      if (v == 481) checkOutput("pixel_y_479", 32'(pixel_y), 32'd479);
    end
    flush(0);
    checkOutput("vsync_lines", 32'(vs_cnt), 32'd2);
    checkOutput("video_lines", 32'(vid_cnt), 32'd480);

    for (int i = 0; i < 254; i++) begin
      applyStimulus(0, 0);
      applyStimulus(5, 0);
    end
    flush(0);
    checkOutput("fc_255", 32'(frame_count), 32'd255);
    applyStimulus(0, 0);
    flush(0);
    checkOutput("fc_wrap", 32'(frame_count), 32'd0);

    applyStimulus(800, 100);
    applyStimulus(760, 100);
    checkOutput("err_set", 32'(count_error), 32'd1);
    applyStimulus(760, 100);
    checkOutput("err_blank_video", 32'(video_on), 32'd0);
    checkOutput("err_blank_hsync", 32'(hsync), 32'd1);
    applyStimulus(100, 525);
    flush(100);
    checkOutput("err_sticky", 32'(count_error), 32'd1);

    applyStimulus(300, 200);
    doReset(300, 200);
    applyStimulus(0, 0);
    applyStimulus(1, 0);
    applyStimulus(2, 0);
    checkOutput("rst2_frame_count", 32'(frame_count), 32'd1);
    checkOutput("rst2_err", 32'(count_error), 32'd0);
    flush(0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
